// File: rtl/thermo_ctrl.sv
// thermo_ctrl: hysteresis heat/cool controller with per-state dwell time and stale-sensor watchdog
module thermo_ctrl #(
  parameter int HYST = 1,
  parameter int MIN_DWELL_CYC = 100_000_000,
  parameter int STALE_CYC = 200_000_000,
  parameter int CNT_W = 28
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       temp_valid_i,
  input  logic [7:0] current_temp,
  input  logic [3:0] set_temp,
  output logic       heat_o,
  output logic       cool_o,
  output logic [1:0] state_o,
  output logic       fault_o
);
  typedef enum logic [1:0] {IDLE = 2'b00, HEAT = 2'b01, COOL = 2'b10, FAULT = 2'b11} state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] dwell, wd;
  logic [8:0] s, t, h, lo, hi;
  always_comb begin
    s = {5'b0, set_temp};
    t = {1'b0, current_temp};
    h = 9'(HYST);
    lo = s >= h ? s - h : 9'd0;
    hi = s + h;
    nxt = state;
    if (!enable_i) nxt = IDLE;
    else if (temp_valid_i) begin
      if (state == FAULT) nxt = IDLE;
      else if (dwell == '0)
        nxt = state == IDLE ? (t < lo ? HEAT : t > hi ? COOL : IDLE) :
              state == HEAT ? (t >= s ? IDLE : HEAT) :
                              (t <= s ? IDLE : COOL);
    end else if (wd >= CNT_W'(STALE_CYC)) nxt = FAULT;
  end
  // Watchdog saturates at STALE_CYC so staying in FAULT never re-arms anything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      dwell <= '0;
      wd <= '0;
    end else begin
      state <= nxt;
      dwell <= nxt != state ? CNT_W'(MIN_DWELL_CYC) : dwell == '0 ? '0 : dwell - 1'b1;
      wd <= (!enable_i || temp_valid_i) ? '0 : wd >= CNT_W'(STALE_CYC) ? wd : wd + 1'b1;
    end
  end
  assign heat_o = state == HEAT;
  assign cool_o = state == COOL;
  assign fault_o = state == FAULT;
  assign state_o = state;
endmodule

// File: tb/tb_thermo_ctrl.sv
// tb_thermo_ctrl: directed scenarios plus randomized run against a behavioural controller model
module tb_thermo_ctrl;
  localparam int HYST = 1, DWELL = 8, STALE = 64;
  logic clk_i = 0, rst_i = 0, enable_i = 0, temp_valid_i = 0;
  logic [7:0] current_temp = 0;
  logic [3:0] set_temp = 0;
  logic heat_o, cool_o, fault_o;
  logic [1:0] state_o;
  int checks = 0, failures = 0;
  int m_state = 0, m_dwell = 0, m_quiet = 0;

  thermo_ctrl #(.HYST(HYST), .MIN_DWELL_CYC(DWELL), .STALE_CYC(STALE), .CNT_W(28)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .temp_valid_i(temp_valid_i),
    .current_temp(current_temp), .set_temp(set_temp), .heat_o(heat_o), .cool_o(cool_o),
    .state_o(state_o), .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [4:0] outs(input int st);
    return {st == 3, st == 2, st == 1, 2'(st)};
  endfunction

  // Model: 0 idle, 1 heat, 2 cool, 3 fault; dwell = cycles left, quiet = edges since last strobe
  task automatic model_step(input logic en, input logic v, input int t, input int s);
    int lo, hi, ns;
    lo = s - HYST < 0 ? 0 : s - HYST;
    hi = s + HYST;
    ns = m_state;
    if (!en) ns = 0;
    else if (v) begin
      if (m_state == 3) ns = 0;
      else if (m_dwell == 0) begin
        if (m_state == 0) ns = t < lo ? 1 : (t > hi ? 2 : 0);
        else if (m_state == 1) ns = t >= s ? 0 : 1;
        else ns = t <= s ? 0 : 2;
      end
    end else if (m_quiet >= STALE) ns = 3;
    m_dwell = ns != m_state ? DWELL : (m_dwell > 0 ? m_dwell - 1 : 0);
    m_quiet = (!en || v) ? 0 : (m_quiet >= STALE ? STALE : m_quiet + 1);
    m_state = ns;
  endtask

  task automatic tick(input logic en, input logic v, input int t, input int s);
    enable_i = en; temp_valid_i = v; current_temp = t[7:0]; set_temp = s[3:0];
    @(posedge clk_i);
    model_step(en, v, t, s);
    #1;
    temp_valid_i = 0;
  endtask

  task automatic do_reset();
    rst_i = 1;
    @(posedge clk_i);
    m_state = 0; m_dwell = 0; m_quiet = 0;
    #1;
    rst_i = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({fault_o, cool_o, heat_o, state_o} !== 5'b0) begin
      failures++; $display("FAIL reset outs=%b exp=%b", {fault_o, cool_o, heat_o, state_o}, 5'b0);
    end
  endtask

  task automatic test_heat();
    tick(1, 1, 8, 10);
    checks++;
    if ({fault_o, cool_o, heat_o, state_o} !== 5'b00101) begin
      failures++; $display("FAIL heat_entry outs=%b exp=%b", {fault_o, cool_o, heat_o, state_o}, 5'b00101);
    end
    tick(1, 0, 0, 10);
    tick(1, 1, 9, 10);
    checks++;
    if (state_o !== 2'b01) begin
      failures++; $display("FAIL heat_dwell_ignore state=%b exp=01", state_o);
    end
    repeat (6) tick(1, 0, 0, 10);
    tick(1, 1, 10, 10);
    checks++;
    if ({heat_o, state_o} !== 3'b000) begin
      failures++; $display("FAIL heat_exit heat=%b state=%b exp=0/00", heat_o, state_o);
    end
  endtask

  task automatic test_band_cool();
    repeat (8) tick(1, 0, 0, 10);
    tick(1, 1, 9, 10);
    tick(1, 1, 11, 10);
    checks++;
    if (state_o !== 2'b00) begin
      failures++; $display("FAIL band_hold state=%b exp=00", state_o);
    end
    tick(1, 1, 12, 10);
    checks++;
    if ({fault_o, cool_o, heat_o, state_o} !== 5'b01010) begin
      failures++; $display("FAIL cool_entry outs=%b exp=%b", {fault_o, cool_o, heat_o, state_o}, 5'b01010);
    end
    repeat (8) tick(1, 0, 0, 10);
    tick(1, 1, 10, 10);
    checks++;
    if (state_o !== 2'b00) begin
      failures++; $display("FAIL cool_exit state=%b exp=00", state_o);
    end
  endtask

  task automatic test_setpoint_change();
    repeat (8) tick(1, 0, 0, 10);
    tick(1, 1, 5, 10);
    repeat (8) tick(1, 0, 0, 10);
    tick(1, 1, 200, 0);
    checks++;
    if (state_o !== 2'b00) begin
      failures++; $display("FAIL no_heat_to_cool state=%b exp=00", state_o);
    end
    repeat (8) tick(1, 0, 0, 0);
    tick(1, 1, 200, 0);
    checks++;
    if (state_o !== 2'b10) begin
      failures++; $display("FAIL cool_after_idle state=%b exp=10", state_o);
    end
    repeat (8) tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
  endtask

  task automatic test_clamp();
    repeat (8) tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    checks++;
    if (state_o !== 2'b00) begin
      failures++; $display("FAIL lo_clamp state=%b exp=00", state_o);
    end
    tick(1, 1, 255, 15);
    checks++;
    if (state_o !== 2'b10) begin
      failures++; $display("FAIL hi_max state=%b exp=10", state_o);
    end
    repeat (8) tick(1, 0, 0, 15);
    tick(1, 1, 15, 15);
  endtask

  task automatic test_watchdog();
    repeat (8) tick(1, 0, 0, 10);
    tick(1, 1, 5, 10);
    repeat (STALE) tick(1, 0, 0, 10);
    checks++;
    if (state_o !== 2'b01) begin
      failures++; $display("FAIL wd_early state=%b exp=01", state_o);
    end
    tick(1, 0, 0, 10);
    checks++;
    if ({fault_o, cool_o, heat_o, state_o} !== 5'b10011) begin
      failures++; $display("FAIL wd_fault outs=%b exp=%b", {fault_o, cool_o, heat_o, state_o}, 5'b10011);
    end
    tick(1, 1, 5, 10);
    checks++;
    if ({fault_o, state_o} !== 3'b000) begin
      failures++; $display("FAIL fault_exit fault=%b state=%b exp=0/00", fault_o, state_o);
    end
    repeat (8) tick(1, 0, 0, 10);
    tick(1, 1, 5, 10);
    repeat (STALE) tick(1, 0, 0, 10);
    tick(1, 1, 5, 10);
    checks++;
    if ({fault_o, state_o} !== 3'b001) begin
      failures++; $display("FAIL wd_strobe_race fault=%b state=%b exp=0/01", fault_o, state_o);
    end
  endtask

  task automatic test_enable_reset();
    tick(1, 1, 10, 10);
    repeat (8) tick(1, 0, 0, 10);
    tick(1, 1, 20, 10);
    tick(0, 0, 20, 10);
    checks++;
    if ({cool_o, state_o} !== 3'b000) begin
      failures++; $display("FAIL enable_drop cool=%b state=%b exp=0/00", cool_o, state_o);
    end
    repeat (8) tick(1, 0, 0, 10);
    tick(1, 1, 5, 10);
    do_reset();
    checks++;
    if ({fault_o, cool_o, heat_o, state_o} !== 5'b0) begin
      failures++; $display("FAIL mid_reset outs=%b exp=%b", {fault_o, cool_o, heat_o, state_o}, 5'b0);
    end
  endtask

  task automatic test_random();
    int p;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) p = ($urandom_range(0, 1) == 0) ? 2 : 30;
      if ($urandom_range(0, 499) == 0) do_reset();
      else tick($urandom_range(0, 99) < 95, $urandom_range(0, 99) < p,
                $urandom_range(0, 19) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 20),
                $urandom_range(0, 15));
      checks++;
      if ({fault_o, cool_o, heat_o, state_o} !== outs(m_state) || (heat_o && cool_o)) begin
        failures++;
        $display("FAIL random cyc=%0d outs=%b exp=%b", i, {fault_o, cool_o, heat_o, state_o}, outs(m_state));
      end
    end
  endtask

  initial begin
    test_reset();
    test_heat();
    test_band_cool();
    test_setpoint_change();
    test_clamp();
    test_watchdog();
    test_enable_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/thermo_ctrl.md
Name: thermo_ctrl

Overview:
Closed-loop actuator controller downstream of the set-temperature entry stage. Consumes the sensor reading (current_temp) and the user setpoint (set_temp), and drives mutually exclusive heater and cooler enables. Uses a hysteresis band, a minimum dwell time per state, and a sensor-staleness watchdog that forces a safe FAULT state.

Parameters:
HYST, 1, hysteresis half-band in degrees (temperature LSBs)
MIN_DWELL_CYC, 100_000_000, minimum clock cycles spent in a state before a sample-driven transition is allowed
STALE_CYC, 200_000_000, cycles without temp_valid_i before FAULT
CNT_W, 28, width of the dwell and watchdog counters; must hold both MIN_DWELL_CYC and STALE_CYC

Ports:
clk_i  in  1  system clock; single clock domain
rst_i  in  1  synchronous, active-high reset
enable_i  in  1  control enable; low forces IDLE with actuators off
temp_valid_i  in  1  one-cycle strobe; current_temp is valid this cycle
current_temp  in  8  unsigned sensor temperature
set_temp  in  4  unsigned setpoint, zero-extended internally to 8 bits
heat_o  out  1  heater enable
cool_o  out  1  cooler enable
state_o  out  2  encoding: 00 IDLE, 01 HEAT, 10 COOL, 11 FAULT
fault_o  out  1  high while in FAULT

Behaviour:
- Reset (rst_i high at a clk_i edge): state IDLE, dwell counter 0, watchdog 0. heat_o, cool_o and fault_o are 0; state_o is 00.
- Outputs decode directly from the state register, so there is no extra latency:
  - heat_o = (state == HEAT)
  - cool_o = (state == COOL)
  - fault_o = (state == FAULT)
  - heat_o and cool_o are never both 1.
- Comparison arithmetic: all compares are done in 9 bits, so nothing underflows or overflows.
  - S = {1'b0, 4'b0, set_temp}, T = {1'b0, current_temp}.
  - lo = S - HYST, clamped at 0. hi = S + HYST.
- Dwell counter:
  - Loaded with MIN_DWELL_CYC on every state change.
  - Decrements by 1 per cycle and saturates at 0.
  - "Dwell done" means counter == 0.
- Sample-driven transitions are evaluated only on a cycle where temp_valid_i = 1, enable_i = 1 and dwell done. The new state is registered on that edge.
  - IDLE -> HEAT if T < lo.
  - IDLE -> COOL if T > hi.
  - Otherwise IDLE stays IDLE.
  - HEAT -> IDLE if T >= S.
  - COOL -> IDLE if T <= S.
  - HEAT <-> COOL directly is forbidden; the path must pass through IDLE with a full dwell.
  - A sample arriving while dwell is not done is ignored. It is not queued.
- Watchdog:
  - Cleared on any temp_valid_i cycle, and held at 0 while enable_i = 0.
  - Otherwise increments, saturating.
  - When it reaches STALE_CYC, the next edge enters FAULT, ignoring dwell.
- FAULT:
  - Actuators are off.
  - Exits to IDLE on the first temp_valid_i with enable_i = 1, ignoring dwell; the dwell counter is loaded on exit.
  - Staying in FAULT does not re-trigger anything.
- enable_i = 0: the next edge enters IDLE from any state, bypassing dwell, and clears FAULT. The dwell counter is reloaded only if the state actually changed.
- Priority of simultaneous events, highest first: rst_i, then enable_i low, then temp_valid_i (clears watchdog and suppresses FAULT entry that same cycle), then watchdog expiry, then sample-driven transitions.
- set_temp may change at any time; it is sampled only on temp_valid_i cycles.
- Reset mid-operation takes effect on the next edge regardless of dwell or watchdog state.

Test Plan:
Use HYST = 1, MIN_DWELL_CYC = 8, STALE_CYC = 64 for all scenarios.
1. Reset, then enable = 1, set_temp = 10, strobe T = 8 -> state 01 and heat_o = 1 the edge after the strobe. A strobe with T = 9 two cycles later is ignored (dwell). A strobe with T = 10 after 8 cycles -> IDLE and heat_o = 0.
2. set_temp = 10, strobe T = 9 or T = 11 from IDLE -> stays IDLE (inside band). Strobe T = 12 -> COOL, cool_o = 1. Strobe T = 10 after dwell -> IDLE.
3. In HEAT, set_temp changes to 0 and a strobe with T = 200 arrives after dwell -> IDLE only, never COOL. The next strobe after a further 8 cycles -> COOL.
4. set_temp = 0, strobe T = 0 -> IDLE (lo clamps at 0, no underflow). set_temp = 15, strobe T = 255 -> COOL.
5. No strobe for 64 cycles while in HEAT -> FAULT: state_o = 11, fault_o = 1, heat_o = 0. A strobe on the same cycle the watchdog would hit 64 -> no FAULT. After FAULT, a strobe -> IDLE.
6. In COOL with dwell active, drop enable_i -> IDLE next edge. Assert rst_i while in HEAT -> all outputs 0 next edge.
